hamming_enc_engine: RTL

HAMMING_ENC_ENGINE -- requirements
Module: hamming_enc_engine

---
 rtl/hamming_enc_engine.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/hamming_enc_engine.sv
// Batch Hamming (16,11) SEC-DED encoder: reads NUM_MSG 11-bit messages from byte memory,
// writes each encoded 16-bit word back as two bytes, then raises done.
module hamming_enc_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [2:0] fsm_state
);

  // Handshake: req is a level sampled only in IDLE (ignored elsewhere); done rises one
  // cycle after the DONE state and stays high until the next accepted req clears it.

  localparam int              IDX_W    = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MSG - 1);
  localparam logic [7:0]      SRC_B    = 8'(SRC_BASE);
  localparam logic [7:0]      DST_B    = 8'(DST_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [8:1]       d_lo;
  logic [11:9]      d_hi;
  logic [11:1]      d;
  logic             p8;
  logic             p4;
  logic             p2;
  logic             p1;
  logic             p0;
  logic [15:0]      word;
  logic [7:0]       idx_x2;
  logic [7:0]       src_addr;
  logic [7:0]       dst_addr;
  logic             accept;
  logic             last_msg;

  assign fsm_state = state;
  assign accept    = (state == IDLE) && req;
  assign last_msg  = (idx == LAST_IDX);

  // Byte addresses are 8-bit and wrap modulo 256.
  assign idx_x2   = 8'({idx, 1'b0});
  assign src_addr = SRC_B + idx_x2;
  assign dst_addr = DST_B + idx_x2;

  assign d  = {d_hi, d_lo};
  assign p8 = ^d[11:5];
  assign p4 = ^{d[11:8], d[4:2]};
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = ^{d, p8, p4, p2, p1};

  assign word = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      done <= 1'b0;
      d_lo <= '0;
      d_hi <= '0;
    end else begin
      if (accept) begin
        idx  <= '0;
        done <= 1'b0;
      end else if (state == WR_HI && !last_msg) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == DONE) begin
        done <= 1'b1;
      end
      if (state == RD_LO) begin
        d_lo <= mem_rd_data;
      end
      if (state == RD_HI) begin
        d_hi <= mem_rd_data[2:0];
      end
    end
  end

  // Memory outputs decode straight from state, so reset zeroes them immediately.
  always_comb begin
    state_nxt   = state;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = RD_LO;
        end
      end
      RD_LO: begin
        mem_addr  = src_addr;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = src_addr + 8'd1;
        state_nxt = WR_LO;
      end
      WR_LO: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = word[7:0];
        state_nxt   = WR_HI;
      end
      WR_HI: begin
        mem_addr    = dst_addr + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = word[15:8];
        state_nxt   = last_msg ? DONE : RD_LO;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
